ula_sched: RTL and testbench

ULA_SCHED -- requirements
Module: ula_sched

---
 rtl/ula_sched.sv | 137 +++++++++++++
 tb/tb_ula_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_sched.sv
// Round-robin scheduler sharing one ULA between two requesters (IDLE -> EXEC -> RESP).
// Optional macro ULA_SCHED_STAT_EN adds a 16-bit completed-response counter (stat_count).
module ula_sched #(
    parameter int N       = 8,
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 2
) (
    input  logic            Tclk,
    input  logic            Tclr,
    input  logic            req0_valid,
    input  logic            req1_valid,
    output logic            req0_ready,
    output logic            req1_ready,
    input  logic [N-1:0]    req0_a,
    input  logic [N-1:0]    req0_b,
    input  logic [N-1:0]    req1_a,
    input  logic [N-1:0]    req1_b,
    input  logic [2:0]      req0_op,
    input  logic [2:0]      req1_op,
    output logic [N-1:0]    ula_a,
    output logic [N-1:0]    ula_b,
    output logic [2:0]      ula_sel,
    output logic            ula_en,
    input  logic [N:0]      ula_s,
    input  logic [2*N-1:0]  ula_smulti,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [2*N-1:0]  rsp_data,
    output logic            busy,
    output logic [1:0]      dbg_state
`ifdef ULA_SCHED_STAT_EN
    ,
    output logic [15:0]     stat_count
`endif
);

    // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
    // valid may drop while not granted, and rsp_data/rsp_id stay stable while rsp_valid waits for rsp_ready.

    localparam int MAXL = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
    localparam int CW   = (MAXL < 2) ? 1 : $clog2(MAXL);
    localparam logic [CW-1:0] ALU_LAST = CW'(ALU_LAT - 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [2:0]    OP_MUL   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_ptr;
    logic [CW-1:0]   r_cnt;

    logic            w_idle;
    logic            w_acc;
    logic            w_win;
    logic [N-1:0]    w_a;
    logic [N-1:0]    w_b;
    logic [2:0]      w_op;

    assign w_idle = (r_state == IDLE);

    // r_ptr = 0 favours req0 when both are valid; reset also masks ready.
    assign req0_ready = w_idle & Tclr & req0_valid & (~req1_valid | ~r_ptr);
    assign req1_ready = w_idle & Tclr & req1_valid & (~req0_valid |  r_ptr);

    assign w_acc = req0_ready | req1_ready;
    assign w_win = req1_ready;
    assign w_a   = w_win ? req1_a  : req0_a;
    assign w_b   = w_win ? req1_b  : req0_b;
    assign w_op  = w_win ? req1_op : req0_op;

    assign ula_en    = (r_state == EXEC);
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

    always_ff @(posedge Tclk or negedge Tclr) begin
        if (!Tclr) begin
            r_state  <= IDLE;
            r_ptr    <= 1'b0;
            r_cnt    <= '0;
            ula_a    <= '0;
            ula_b    <= '0;
            ula_sel  <= '0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        ula_a   <= w_a;
                        ula_b   <= w_b;
                        ula_sel <= w_op;
                        rsp_id  <= w_win;
                        r_ptr   <= ~w_win;
                        r_cnt   <= (w_op == OP_MUL) ? MUL_LAST : ALU_LAST;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt == '0) begin
                        rsp_data <= (ula_sel == OP_MUL) ? ula_smulti
                                                        : {{(N-1){1'b0}}, ula_s};
                        r_state  <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ULA_SCHED_STAT_EN
    logic [15:0] r_stat;

    always_ff @(posedge Tclk or negedge Tclr) begin
        if (!Tclr) begin
            r_stat <= '0;
        end else if (rsp_valid && rsp_ready) begin
            r_stat <= r_stat + 16'd1;
        end
    end

    assign stat_count = r_stat;
`endif

endmodule

// File: tb/tb_ula_sched.sv
// Directed self-checking bench for ula_sched with a behavioural ULA (sum and product).
// Covers reset, multiply/add latency, round-robin order, response back-pressure and mid-op reset.
module tb_ula_sched;

    localparam int N       = 8;
    localparam int ALU_LAT = 1;
    localparam int MUL_LAT = 2;

    logic            Tclk;
    logic            Tclr;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [N-1:0]    req0_a, req0_b, req1_a, req1_b;
    logic [2:0]      req0_op, req1_op;
    logic [N-1:0]    ula_a, ula_b;
    logic [2:0]      ula_sel;
    logic            ula_en;
    logic [N:0]      ula_s;
    logic [2*N-1:0]  ula_smulti;
    logic            rsp_valid, rsp_ready, rsp_id;
    logic [2*N-1:0]  rsp_data;
    logic            busy;
    logic [1:0]      dbg_state;
`ifdef ULA_SCHED_STAT_EN
    logic [15:0]     stat_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ula_sched #(.N(N), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
        .Tclk       (Tclk),
        .Tclr       (Tclr),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .ula_a      (ula_a),
        .ula_b      (ula_b),
        .ula_sel    (ula_sel),
        .ula_en     (ula_en),
        .ula_s      (ula_s),
        .ula_smulti (ula_smulti),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .dbg_state  (dbg_state)
`ifdef ULA_SCHED_STAT_EN
        ,
        .stat_count (stat_count)
`endif
    );

    // Behavioural ULA: carry-keeping sum and full-width product.
    assign ula_s      = {1'b0, ula_a} + {1'b0, ula_b};
    assign ula_smulti = (2*N)'(ula_a) * (2*N)'(ula_b);

    // Clock and reset
    initial Tclk = 1'b0;
    always #5 Tclk = ~Tclk;
    always @(posedge Tclk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Tclk);
        #1;
    endtask

    // Called just after the accepting edge; counts edges until rsp_valid.
    task automatic wait_rsp(input int lat, input string tag);
        int c;
        int en;
        c  = 0;
        en = 0;
        while (!rsp_valid && c < 50) begin
            if (ula_en) en++;
            tick();
            c++;
        end
        check_eq({tag, "_lat"}, c, lat);
        check_eq({tag, "_en_cycles"}, en, lat);
    endtask

    task automatic wait_ready(output int gnt, output int at_cyc);
        int c;
        c = 0;
        while (!(req0_ready || req1_ready) && c < 50) begin
            tick();
            c++;
        end
        if (c >= 50) check_eq("ready_timeout", c, 0);
        gnt    = req1_ready ? 1 : 0;
        at_cyc = cyc;
    endtask

    initial begin
        int g;
        int t;
        int t_prev;
        t_prev     = 0;
        Tclr       = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready  = 1'b0;

        // Reset state, with both valids up to show ready is masked
        #2 Tclr = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_eq("rst_ula_a", ula_a, 0);
        check_eq("rst_ula_b", ula_b, 0);
        check_eq("rst_ula_sel", ula_sel, 0);
        check_eq("rst_ula_en", ula_en, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_id", rsp_id, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_state", dbg_state, 0);
        check_eq("rst_ready0", req0_ready, 0);
        check_eq("rst_ready1", req1_ready, 0);
        req1_valid = 1'b0;

        // Multiply from req0, accepted in the first cycle after reset release
        @(negedge Tclk);
        Tclr      = 1'b1;
        req0_a    = 8'd55;
        req0_b    = 8'd10;
        req0_op   = 3'b111;
        rsp_ready = 1'b1;
        #1;
        check_eq("mul_ready0", req0_ready, 1);
        check_eq("mul_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        check_eq("mul_busy", busy, 1);
        wait_rsp(MUL_LAT, "mul");
        check_eq("mul_data", rsp_data, 550);
        check_eq("mul_id", rsp_id, 0);
        check_eq("mul_sel", ula_sel, 7);
        tick();
        check_eq("mul_done_valid", rsp_valid, 0);
        check_eq("mul_done_busy", busy, 0);
        check_eq("hold_ula_a", ula_a, 55);
        check_eq("hold_ula_b", ula_b, 10);

        // Add from req1 with 9-bit carry
        req1_valid = 1'b1;
        req1_a     = 8'd100;
        req1_b     = 8'd254;
        req1_op    = 3'b000;
        #1;
        check_eq("add_ready1", req1_ready, 1);
        check_eq("add_ready0", req0_ready, 0);
        tick();
        req1_valid = 1'b0;
        wait_rsp(ALU_LAT, "add");
        check_eq("add_data", rsp_data, 354);
        check_eq("add_id", rsp_id, 1);
        tick();

        // Round-robin with both valid continuously after a reset
        Tclr = 1'b0;
        #1;
        Tclr = 1'b1;
        req0_a = 8'd3;   req0_b = 8'd4;   req0_op = 3'b000;
        req1_a = 8'd200; req1_b = 8'd100; req1_op = 3'b000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            wait_ready(g, t);
            check_eq("rr_order", g, i % 2);
            if (i > 0) check_eq("rr_spacing", t - t_prev, ALU_LAT + 2);
            t_prev = t;
            tick();
            wait_rsp(ALU_LAT, "rr");
            check_eq("rr_data", rsp_data, (i % 2) ? 300 : 7);
            check_eq("rr_id", rsp_id, i % 2);
            tick();
`ifdef ULA_SCHED_STAT_EN
            check_eq("stat_count", stat_count, i + 1);
`endif
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;

        // Back-pressure in RESP, req1 kept valid the whole time
        req0_valid = 1'b1;
        req0_a     = 8'd255;
        req0_b     = 8'd255;
        req0_op    = 3'b111;
        req1_valid = 1'b1;
        req1_a     = 8'd1;
        req1_b     = 8'd2;
        req1_op    = 3'b000;
        rsp_ready  = 1'b0;
        #1;
        check_eq("bp_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        wait_rsp(MUL_LAT, "bp");
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", rsp_valid, 1);
            check_eq("bp_data", rsp_data, 65025);
            check_eq("bp_id", rsp_id, 0);
            check_eq("bp_no_ready", req0_ready | req1_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("hs_no_ready", req1_ready, 0);
        tick();
        check_eq("hs_valid_drop", rsp_valid, 0);
        check_eq("hs_next_ready1", req1_ready, 1);
        req1_valid = 1'b0;
        #1;

        // Reset in the middle of EXEC (pointer now favours req1)
        req0_a = 8'd2; req0_b = 8'd3; req0_op = 3'b111;
        req1_a = 8'd9; req1_b = 8'd9; req1_op = 3'b111;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_eq("mid_ready1", req1_ready, 1);
        check_eq("mid_ready0", req0_ready, 0);
        tick();
        tick();
        check_eq("mid_in_exec", ula_en, 1);
        #2 Tclr = 1'b0;
        #1;
        check_eq("mid_rst_ula_a", ula_a, 0);
        check_eq("mid_rst_ula_b", ula_b, 0);
        check_eq("mid_rst_sel", ula_sel, 0);
        check_eq("mid_rst_en", ula_en, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_rsp_id", rsp_id, 0);
        check_eq("mid_rst_ready", req0_ready | req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge Tclk);
        Tclr = 1'b1;
        #1;
        for (int i = 0; i < MUL_LAT + 2; i++) begin
            check_eq("mid_no_rsp", rsp_valid, 0);
            tick();
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_eq("post_rst_ready0", req0_ready, 1);
        check_eq("post_rst_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(MUL_LAT, "post_rst");
        check_eq("post_rst_data", rsp_data, 6);
        check_eq("post_rst_id", rsp_id, 0);
        tick();
`ifdef ULA_SCHED_STAT_EN
        check_eq("stat_after_rst", stat_count, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
